// File: rtl/wb_common_pkg.sv
// Shared Wishbone definitions for the width-converter bridges: bus constants,
// the bridge FSM state type and a constant-safe clog2.
package wb_common_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_t;

  typedef enum logic [1:0] {
    RSP_ACK = 2'd0,
    RSP_ERR = 2'd1,
    RSP_RTY = 2'd2
  } wb_resp_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_lane_next.sv
// Priority encoder over a lane-active mask: returns the lowest active lane,
// either from lane 0 (start=1) or strictly above the current lane.
module wb_lane_next
  import wb_common_pkg::*;
#(
  parameter int R  = 4,
  parameter int KW = 2
) (
  input  logic [R-1:0]  mask,
  input  logic [KW-1:0] cur,
  input  logic          start,
  output logic [KW-1:0] nxt,
  output logic          none
);

  // Scan downwards so the lowest qualifying lane is the last one written.
  always_comb begin
    nxt  = '0;
    none = 1'b1;
    for (int i = R - 1; i >= 0; i--) begin
      if (mask[i] && (start || (i > int'(cur)))) begin
        nxt  = KW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_data_split.sv
// Wishbone data-width downsizer: one wide master access becomes one narrow
// slave beat per selected sub-word, in address order, with a single response.
module wb_data_split
  import wb_common_pkg::*;
#(
  parameter int aw         = 32,
  parameter int mdw        = 32,
  parameter int sdw        = 8,
  parameter int BIG_ENDIAN = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [aw-1:0]    wbm_adr_i,
  input  logic [mdw-1:0]   wbm_dat_i,
  input  logic [mdw/8-1:0] wbm_sel_i,
  input  logic             wbm_we_i,
  input  logic             wbm_cyc_i,
  input  logic             wbm_stb_i,
  input  logic [2:0]       wbm_cti_i,
  input  logic [1:0]       wbm_bte_i,
  output logic [mdw-1:0]   wbm_dat_o,
  output logic             wbm_ack_o,
  output logic             wbm_err_o,
  output logic             wbm_rty_o,
  output logic [aw-1:0]    wbs_adr_o,
  output logic [sdw-1:0]   wbs_dat_o,
  output logic [sdw/8-1:0] wbs_sel_o,
  output logic             wbs_we_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  output logic [2:0]       wbs_cti_o,
  output logic [1:0]       wbs_bte_o,
  input  logic [sdw-1:0]   wbs_dat_i,
  input  logic             wbs_ack_i,
  input  logic             wbs_err_i,
  input  logic             wbs_rty_i
);

  localparam int R    = mdw / sdw;
  localparam int KW   = clog2(R);
  localparam int SB   = sdw / 8;
  localparam int MB   = mdw / 8;
  localparam int SOFF = clog2(SB);

  // Handshake: the master request is taken when cyc&stb are high in IDLE and
  // answered by a one-cycle ack/err/rty. Each slave beat is offered while
  // wbs_cyc_o&wbs_stb_o are high and completes on the first cycle ack, err or
  // rty is seen; stb then drops for at least one cycle (classic, no pipelining).

  wb_state_t      state, state_d;
  wb_resp_t       resp_q, resp_d;
  logic [aw-1:0]  adr_q, adr_d;
  logic [mdw-1:0] dat_q, dat_d;
  logic [MB-1:0]  sel_q, sel_d;
  logic [KW-1:0]  k_q, k_d;
  logic [aw-1:0]  sadr_d;
  logic [sdw-1:0] sdat_d;
  logic [SB-1:0]  ssel_d;
  logic           swe_d, scyc_d, sstb_d;
  logic [mdw-1:0] mdat_d;
  logic           ack_d, err_d, rty_d;
  logic [R-1:0]   act_mask;
  logic [KW-1:0]  lane_nxt;
  logic           lane_none;
  logic           resp_out;
  logic           unused_burst;

  assign wbs_cti_o    = CTI_CLASSIC;
  assign wbs_bte_o    = BTE_LINEAR;
  assign unused_burst = ^{wbm_cti_i, wbm_bte_i};
  assign resp_out     = wbm_ack_o | wbm_err_o | wbm_rty_o;

  function automatic int lane_pos(input logic [KW-1:0] k);
    if (BIG_ENDIAN != 0) return R - 1 - int'(k);
    else return int'(k);
  endfunction

  function automatic logic [SB-1:0] lane_sel(input logic [MB-1:0] sel, input logic [KW-1:0] k);
    return sel[lane_pos(k)*SB +: SB];
  endfunction

  function automatic logic [sdw-1:0] lane_dat(input logic [mdw-1:0] d, input logic [KW-1:0] k);
    return d[lane_pos(k)*sdw +: sdw];
  endfunction

  function automatic logic [aw-1:0] lane_adr(input logic [aw-1:0] a, input logic [KW-1:0] k);
    logic [aw-1:0] base;
    base = a & ~aw'(MB - 1);
    return base | (aw'(k) << SOFF);
  endfunction

  // In IDLE the mask comes straight from the bus so the first lane is known
  // at the accept edge; afterwards it comes from the latched selects.
  always_comb begin
    act_mask = '0;
    for (int i = 0; i < R; i++) begin
      act_mask[i] = (state == ST_IDLE) ? (|lane_sel(wbm_sel_i, KW'(i)))
                                       : (|lane_sel(sel_q, KW'(i)));
    end
  end

  wb_lane_next #(
    .R  (R),
    .KW (KW)
  ) u_lane_next (
    .mask  (act_mask),
    .cur   (k_q),
    .start (state == ST_IDLE),
    .nxt   (lane_nxt),
    .none  (lane_none)
  );

  always_comb begin
    state_d = state;
    resp_d  = resp_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    k_d     = k_q;
    sadr_d  = wbs_adr_o;
    sdat_d  = wbs_dat_o;
    ssel_d  = wbs_sel_o;
    swe_d   = wbs_we_o;
    scyc_d  = wbs_cyc_o;
    sstb_d  = wbs_stb_o;
    mdat_d  = wbm_dat_o;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rty_d   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // The cycle carrying our previous response still sees the master's
        // old strobe; it must not start a second access.
        if (wbm_cyc_i && wbm_stb_i && !resp_out) begin
          adr_d  = wbm_adr_i;
          dat_d  = wbm_dat_i;
          sel_d  = wbm_sel_i;
          swe_d  = wbm_we_i;
          mdat_d = '0;
          if (lane_none) begin
            resp_d  = RSP_ACK;
            state_d = ST_RESP;
          end else begin
            k_d     = lane_nxt;
            sadr_d  = lane_adr(wbm_adr_i, lane_nxt);
            sdat_d  = lane_dat(wbm_dat_i, lane_nxt);
            ssel_d  = lane_sel(wbm_sel_i, lane_nxt);
            scyc_d  = 1'b1;
            sstb_d  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (!wbm_cyc_i) begin
          scyc_d  = 1'b0;
          sstb_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (wbs_stb_o) begin
          if (wbs_err_i || wbs_rty_i) begin
            resp_d  = wbs_err_i ? RSP_ERR : RSP_RTY;
            scyc_d  = 1'b0;
            sstb_d  = 1'b0;
            state_d = ST_RESP;
          end else if (wbs_ack_i) begin
            if (!wbs_we_o) mdat_d[lane_pos(k_q)*sdw +: sdw] = wbs_dat_i;
            sstb_d = 1'b0;
            if (lane_none) begin
              resp_d  = RSP_ACK;
              scyc_d  = 1'b0;
              state_d = ST_RESP;
            end else begin
              k_d = lane_nxt;
            end
          end
        end else begin
          // Gap cycle: present the next beat from the latched request.
          sadr_d = lane_adr(adr_q, k_q);
          sdat_d = lane_dat(dat_q, k_q);
          ssel_d = lane_sel(sel_q, k_q);
          sstb_d = 1'b1;
        end
      end
      ST_RESP: begin
        ack_d   = (resp_q == RSP_ACK);
        err_d   = (resp_q == RSP_ERR);
        rty_d   = (resp_q == RSP_RTY);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      resp_q    <= RSP_ACK;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      k_q       <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_sel_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
    end else begin
      state     <= state_d;
      resp_q    <= resp_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      k_q       <= k_d;
      wbs_adr_o <= sadr_d;
      wbs_dat_o <= sdat_d;
      wbs_sel_o <= ssel_d;
      wbs_we_o  <= swe_d;
      wbs_cyc_o <= scyc_d;
      wbs_stb_o <= sstb_d;
      wbm_dat_o <= mdat_d;
      wbm_ack_o <= ack_d;
      wbm_err_o <= err_d;
      wbm_rty_o <= rty_d;
    end
  end

endmodule

// File: tb/tb_wb_data_split.sv
// Bench for wb_data_split: directed steps then random accesses, checked
// against a lane-arithmetic model and a scoreboard of expected slave beats.
module tb_wb_data_split;

  localparam int AW  = 32;
  localparam int MDW = 32;
  localparam int SDW = 8;
  localparam int BE  = 1;
  localparam int R   = MDW / SDW;
  localparam int SB  = SDW / 8;
  localparam int MB  = MDW / 8;
  localparam int BW  = AW + 1 + SDW + SB;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  wbm_adr_i;
  logic [MDW-1:0] wbm_dat_i;
  logic [MB-1:0]  wbm_sel_i;
  logic           wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [2:0]     wbm_cti_i;
  logic [1:0]     wbm_bte_i;
  logic [MDW-1:0] wbm_dat_o;
  logic           wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]  wbs_adr_o;
  logic [SDW-1:0] wbs_dat_o;
  logic [SB-1:0]  wbs_sel_o;
  logic           wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]     wbs_cti_o;
  logic [1:0]     wbs_bte_o;
  logic [SDW-1:0] wbs_dat_i;
  logic           wbs_ack_i, wbs_err_i, wbs_rty_i;

  wb_data_split #(.aw(AW), .mdw(MDW), .sdw(SDW), .BIG_ENDIAN(BE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i)
  );

  // ---------------- clock / reset / bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc_n++; end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int             wait_lo = 0, wait_hi = 0, err_beat = 0, rty_beat = 0;
  int             hold_beat = 0, beat_no = 0;
  bit             stray = 1'b0;
  logic [SDW-1:0] sdata_q[$];
  logic [BW-1:0]  obs_q[$];
  logic [BW-1:0]  exp_q[$];
  int             start_q[$];
  int             resp_q[$];

  initial begin
    bit busy;
    int wcnt;
    busy = 1'b0;
    wcnt = 0;
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0; wbs_dat_i = '0;
    forever begin
      @(posedge clk); #1;
      wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0;
      if (rst) begin
        busy = 1'b0;
      end else if (wbs_cyc_o && wbs_stb_o) begin
        if (!busy) begin
          busy = 1'b1;
          beat_no++;
          if (hold_beat != 0 && beat_no >= hold_beat) wcnt = 100000;
          else wcnt = int'($urandom_range(wait_hi, wait_lo));
          obs_q.push_back({wbs_adr_o, wbs_we_o, wbs_dat_o, wbs_sel_o});
          start_q.push_back(cyc_n);
        end
        if (wcnt == 0) begin
          busy = 1'b0;
          resp_q.push_back(cyc_n);
          if (beat_no == err_beat) wbs_err_i = 1'b1;
          if (beat_no == rty_beat) wbs_rty_i = 1'b1;
          if (!wbs_err_i && !wbs_rty_i) begin
            wbs_ack_i = 1'b1;
            if (!wbs_we_o && sdata_q.size() > 0) wbs_dat_i = sdata_q.pop_front();
            else wbs_dat_i = SDW'($urandom);
          end
        end else begin
          wcnt--;
        end
      end else begin
        busy = 1'b0;
        if (stray) begin wbs_ack_i = 1'b1; wbs_err_i = 1'b1; wbs_dat_i = SDW'($urandom); end
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic run_access(input logic [AW-1:0] adr, input logic [MDW-1:0] dat,
                            input logic [MB-1:0] sel, input logic we,
                            output int resp, output logic [MDW-1:0] rdat);
    int             exp_resp, nb, t0, tr, nhi;
    bit             got;
    logic [MDW-1:0] exp_rdat;
    logic [AW-1:0]  base;
    exp_q.delete();
    exp_resp = 0;
    exp_rdat = '0;
    nb       = 0;
    base     = adr & ~AW'(MB - 1);
    for (int k = 0; k < R; k++) begin
      int pos;
      pos = (BE != 0) ? (R - 1 - k) : k;
      if (((sel >> (pos * SB)) & MB'((1 << SB) - 1)) != '0) begin
        nb++;
        exp_q.push_back({base + AW'(k * SB), we, SDW'(dat >> (pos * SDW)), SB'(sel >> (pos * SB))});
        if (nb == err_beat || nb == rty_beat) begin
          exp_resp = (nb == err_beat) ? 1 : 2;
          break;
        end
        if (!we) exp_rdat = exp_rdat | (MDW'(sdata_q[nb-1]) << (pos * SDW));
      end
    end

    obs_q.delete(); start_q.delete(); resp_q.delete();
    beat_no = 0;
    @(posedge clk); #1;
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_sel_i = sel; wbm_we_i = we;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    t0  = cyc_n;
    got = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        wbm_adr_i = $urandom; wbm_dat_i = $urandom; wbm_sel_i = MB'($urandom); wbm_we_i = ~we;
      end
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin got = 1'b1; break; end
    end
    check("resp_seen", 64'(got), 64'd1);
    nhi  = int'(wbm_ack_o) + int'(wbm_err_o) + int'(wbm_rty_o);
    resp = wbm_ack_o ? 0 : wbm_err_o ? 1 : wbm_rty_o ? 2 : 3;
    rdat = wbm_dat_o;
    tr   = cyc_n;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    if (got) check("resp_onehot", 64'(nhi), 64'd1);
    check("resp_kind", 64'(resp), 64'(exp_resp));
    @(posedge clk); #1;
    check("resp_pulse", {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'd0);
    check("slave_idle_after", {62'd0, wbs_cyc_o, wbs_stb_o}, 64'd0);

    check("beat_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("beat%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
    if (exp_q.size() == 0) begin
      check("zero_sel_latency", 64'(tr - t0), 64'd2);
      check("zero_sel_data", 64'(rdat), 64'd0);
    end else if (start_q.size() > 0 && resp_q.size() > 0) begin
      check("first_beat_start", 64'(start_q[0] - t0), 64'd1);
      check("resp_latency", 64'(tr - resp_q[resp_q.size()-1]), 64'd2);
      for (int i = 1; i < start_q.size() && i <= resp_q.size(); i++)
        check("beat_gap", 64'(start_q[i] - resp_q[i-1]), 64'd2);
    end
    if (!we && exp_resp == 0) check("read_data", 64'(rdat), 64'(exp_rdat));
    sdata_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_slave_ctl"}, {61'd0, wbs_cyc_o, wbs_stb_o, wbs_we_o}, 64'd0);
    check({tag, "_slave_adr"}, 64'(wbs_adr_o), 64'd0);
    check({tag, "_slave_dat_sel"}, {55'd0, wbs_dat_o, wbs_sel_o}, 64'd0);
    check({tag, "_master_dat"}, 64'(wbm_dat_o), 64'd0);
    check({tag, "_master_resp"}, {61'd0, wbm_ack_o, wbm_err_o, wbm_rty_o}, 64'd0);
  endtask

  task automatic count_idle_resp(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) n++;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int             resp, n;
    logic [MDW-1:0] rdat;
    rst = 1'b1;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_cti_i = 3'b111; wbm_bte_i = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // 1: full-width big-endian write
    run_access(32'h9000_0004, 32'h1122_3344, 4'b1111, 1'b1, resp, rdat);
    check("t1_first_beat", 64'(obs_q[0][BW-1 -: AW+1+SDW]), {23'd0, 32'h9000_0004, 1'b1, 8'h11});
    check("t1_last_beat", 64'(obs_q[3][BW-1 -: AW+1+SDW]), {23'd0, 32'h9000_0007, 1'b1, 8'h44});

    // 2: single selected byte read
    sdata_q = {8'hA5};
    run_access(32'h9000_0000, 32'h0, 4'b0100, 1'b0, resp, rdat);
    check("t2_addr", 64'(obs_q[0][BW-1 -: AW]), 64'h9000_0001);
    check("t2_data", 64'(rdat), 64'h00A5_0000);

    // 3: sparse select read
    sdata_q = {8'hDE, 8'hAD};
    run_access(32'h9000_0010, 32'h0, 4'b1001, 1'b0, resp, rdat);
    check("t3_data", 64'(rdat), 64'hDE00_00AD);

    // 4: slave error on second beat
    err_beat = 2;
    run_access(32'h9000_0020, 32'hCAFE_F00D, 4'b1111, 1'b1, resp, rdat);
    err_beat = 0;

    // err wins over rty on the same beat
    err_beat = 1; rty_beat = 1;
    run_access(32'h9000_0024, 32'h0, 4'b0011, 1'b0, resp, rdat);
    err_beat = 0; rty_beat = 0;
    rty_beat = 3;
    run_access(32'h9000_0028, 32'h0, 4'b1111, 1'b0, resp, rdat);
    rty_beat = 0;

    // 5: no lanes selected
    run_access(32'h9000_0030, 32'h1234_5678, 4'b0000, 1'b1, resp, rdat);

    // stray slave responses while idle are ignored
    stray = 1'b1;
    count_idle_resp(4, n);
    stray = 1'b0;
    check("stray_resp", 64'(n), 64'd0);

    // 6a: asynchronous reset in the middle of a read
    sdata_q = {8'h5A, 8'h11};
    hold_beat = 2;
    beat_no = 0;
    @(posedge clk); #1;
    wbm_adr_i = 32'h9000_0040; wbm_sel_i = 4'b1111; wbm_we_i = 1'b0;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    for (int c = 0; c < 40 && beat_no < 2; c++) begin @(posedge clk); #1; end
    check("reset_reached_req", 64'(beat_no), 64'd2);
    check("pre_reset_capture", 64'(wbm_dat_o), 64'h5A00_0000);
    #2 rst = 1'b1;
    #1 check_all_zero("mid_req_reset");
    @(posedge clk); #1;
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    rst = 1'b0;
    hold_beat = 0;
    sdata_q.delete();

    // 6b: master drops cyc mid-access
    hold_beat = 1;
    beat_no = 0;
    @(posedge clk); #1;
    wbm_adr_i = 32'h9000_0050; wbm_dat_i = 32'hAABB_CCDD; wbm_sel_i = 4'b1111; wbm_we_i = 1'b1;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
    for (int c = 0; c < 40 && beat_no < 1; c++) begin @(posedge clk); #1; end
    check("abort_reached_req", {62'd0, wbs_cyc_o, wbs_stb_o}, 64'd3);
    check("cti_bte", {59'd0, wbs_cti_o, wbs_bte_o}, 64'd0);
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0;
    @(posedge clk); #1;
    check("abort_slave_drop", {62'd0, wbs_cyc_o, wbs_stb_o}, 64'd0);
    count_idle_resp(4, n);
    check("abort_no_resp", 64'(n), 64'd0);
    hold_beat = 0;

    // random accesses with wait states and occasional err/rty
    for (int it = 0; it < 30; it++) begin
      wait_lo  = 0;
      wait_hi  = int'($urandom_range(2, 0));
      err_beat = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
      rty_beat = ($urandom_range(3, 0) == 0) ? int'($urandom_range(4, 1)) : 0;
      for (int j = 0; j < R; j++) sdata_q.push_back(SDW'($urandom));
      run_access($urandom, $urandom, MB'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), resp, rdat);
    end
    err_beat = 0; rty_beat = 0; wait_hi = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
